// File: rtl/mgmt_wb_pkg.sv
// rtl/mgmt_wb_pkg.sv - shared management Wishbone types and constants
package mgmt_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mprj_wb_timeout_bridge.sv
// rtl/mprj_wb_timeout_bridge.sv - registered mgmt-to-user Wishbone bridge with ack timeout
module mprj_wb_timeout_bridge
    import mgmt_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          TCNT_W         = 8,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              m_cyc_i,
    input  logic              m_stb_i,
    input  logic              m_we_i,
    input  logic [3:0]        m_sel_i,
    input  logic [31:0]       m_adr_i,
    input  logic [31:0]       m_dat_i,
    output logic              m_ack_o,
    output logic [31:0]       m_dat_o,
    input  logic              wb_iena_i,
    output logic              u_cyc_o,
    output logic              u_stb_o,
    output logic              u_we_o,
    output logic [3:0]        u_sel_o,
    output logic [31:0]       u_adr_o,
    output logic [31:0]       u_dat_o,
    input  logic              u_ack_i,
    input  logic [31:0]       u_dat_i,
    input  logic              tmo_clr_i,
    output logic              tmo_flag_o,
    output logic [TCNT_W-1:0] tmo_cnt_o
);

    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e         state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              ack_ok;
    logic              expired;
    logic              tmo_set;

    // An abort (m_cyc_i low) outranks both the ack and the timeout.
    always_comb begin
        ack_ok  = u_ack_i & wb_iena_i;
        expired = (wait_cnt == WCNT_LAST);
        tmo_set = (state == ST_REQ) && m_cyc_i && !ack_ok && expired;
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            m_ack_o    <= 1'b0;
            m_dat_o    <= '0;
            u_cyc_o    <= 1'b0;
            u_stb_o    <= 1'b0;
            u_we_o     <= 1'b0;
            u_sel_o    <= '0;
            u_adr_o    <= '0;
            u_dat_o    <= '0;
            tmo_flag_o <= 1'b0;
            tmo_cnt_o  <= '0;
        end else begin
            m_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        u_we_o   <= m_we_i;
                        u_sel_o  <= m_sel_i;
                        u_adr_o  <= m_adr_i;
                        u_dat_o  <= m_dat_i;
                        u_cyc_o  <= 1'b1;
                        u_stb_o  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!m_cyc_i) begin
                        u_cyc_o <= 1'b0;
                        u_stb_o <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (ack_ok) begin
                        if (!u_we_o) begin
                            m_dat_o <= u_dat_i;
                        end
                        m_ack_o <= 1'b1;
                        u_cyc_o <= 1'b0;
                        u_stb_o <= 1'b0;
                        state   <= ST_RESP;
                    end else if (expired) begin
                        m_dat_o <= ERR_DATA;
                        m_ack_o <= 1'b1;
                        u_cyc_o <= 1'b0;
                        u_stb_o <= 1'b0;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // The master still shows stb here; the return to IDLE skips it.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (tmo_set) begin
                tmo_flag_o <= 1'b1;
            end else if (tmo_clr_i) begin
                tmo_flag_o <= 1'b0;
            end

            if (tmo_set && (tmo_cnt_o != {TCNT_W{1'b1}})) begin
                tmo_cnt_o <= tmo_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mprj_wb_timeout_bridge.sv
// tb/tb_mprj_wb_timeout_bridge.sv - scoreboard bench for mprj_wb_timeout_bridge
module tb_mprj_wb_timeout_bridge;

    localparam int TMO = 16;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [3:0]  m_sel_i = '0;
    logic [31:0] m_adr_i = '0, m_dat_i = '0;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        wb_iena_i = 1'b1;
    logic        u_cyc_o, u_stb_o, u_we_o;
    logic [3:0]  u_sel_o;
    logic [31:0] u_adr_o, u_dat_o;
    logic        u_ack_i = 1'b0;
    logic [31:0] u_dat_i = '0;
    logic        tmo_clr_i = 1'b0;
    logic        tmo_flag_o;
    logic [7:0]  tmo_cnt_o;

    mprj_wb_timeout_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .TCNT_W(8),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o), .wb_iena_i(wb_iena_i),
        .u_cyc_o(u_cyc_o), .u_stb_o(u_stb_o), .u_we_o(u_we_o),
        .u_sel_o(u_sel_o), .u_adr_o(u_adr_o), .u_dat_o(u_dat_o),
        .u_ack_i(u_ack_i), .u_dat_i(u_dat_i), .tmo_clr_i(tmo_clr_i),
        .tmo_flag_o(tmo_flag_o), .tmo_cnt_o(tmo_cnt_o)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [31:0] dat;
        logic        flag;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic mon_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every m_ack_o pulse must match the oldest expected response.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge core_clk);
            if (mon_en && m_ack_o) begin
                chk("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_data", m_dat_o, e.dat);
                    chk("resp_flag", {31'd0, tmo_flag_o}, {31'd0, e.flag});
                    chk("resp_cnt", {24'd0, tmo_cnt_o}, {24'd0, e.cnt});
                end
            end
            prev_ack = m_ack_o;
        end
    end

    task automatic push_exp(input logic [31:0] dat, input logic flag, input logic [7:0] cnt);
        exp_t e;
        e.dat = dat; e.flag = flag; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic do_txn(input string name, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] wdat, input int ack_at,
                          input logic [31:0] udat, input logic iena, input int clr_at,
                          input int exp_stb);
        int   stb_n, gaps;
        logic got;
        @(negedge core_clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr; m_sel_i = sel; m_dat_i = wdat;
        wb_iena_i = iena; u_dat_i = udat;
        stb_n = 0; gaps = 0; got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge core_clk);
            u_ack_i = 1'b0; tmo_clr_i = 1'b0;
            if (m_ack_o) begin
                got = 1'b1;
            end else if (u_stb_o) begin
                stb_n++;
                if (stb_n == 1) begin
                    chk({name, "_u_cyc"}, {31'd0, u_cyc_o}, 32'd1);
                    chk({name, "_u_we"}, {31'd0, u_we_o}, {31'd0, we});
                    chk({name, "_u_adr"}, u_adr_o, adr);
                    chk({name, "_u_sel"}, {28'd0, u_sel_o}, {28'd0, sel});
                    chk({name, "_u_dat"}, u_dat_o, wdat);
                end
                if (stb_n == ack_at) u_ack_i = 1'b1;
                if (stb_n == clr_at) tmo_clr_i = 1'b1;
            end else begin
                gaps++;
            end
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        chk({name, "_ack_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_stb_cycles"}, stb_n, exp_stb);
        chk({name, "_latency_gaps"}, gaps, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stb_n;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_ack", {31'd0, m_ack_o}, 32'd0);
        chk("rst_ucyc", {31'd0, u_cyc_o}, 32'd0);
        chk("rst_ustb", {31'd0, u_stb_o}, 32'd0);
        chk("rst_mdat", m_dat_o, 32'd0);
        chk("rst_flag", {31'd0, tmo_flag_o}, 32'd0);
        chk("rst_cnt", {24'd0, tmo_cnt_o}, 32'd0);
        core_rst = 1'b0;
        mon_en = 1'b1;

        push_exp(32'h1234_5678, 1'b0, 8'd0);
        do_txn("read_ack", 1'b0, 32'h3000_0000, 4'hF, 32'h0, 3, 32'h1234_5678, 1'b1, -1, 3);

        push_exp(32'hDEAD_BEEF, 1'b1, 8'd1);
        do_txn("write_tmo", 1'b1, 32'h3000_0004, 4'b0011, 32'hAAAA_5555, -1, 32'h0, 1'b1, -1, TMO);

        push_exp(32'hDEAD_BEEF, 1'b1, 8'd1);
        do_txn("write_ack", 1'b1, 32'h3000_0008, 4'b1100, 32'h0BAD_F00D, 2, 32'h5555_AAAA, 1'b1, -1, 2);

        push_exp(32'hDEAD_BEEF, 1'b1, 8'd2);
        do_txn("iena_gate", 1'b0, 32'h3000_000C, 4'hF, 32'h0, 1, 32'h1111_1111, 1'b0, -1, TMO);

        @(negedge core_clk); wb_iena_i = 1'b1; tmo_clr_i = 1'b1;
        @(negedge core_clk); tmo_clr_i = 1'b0;
        chk("clr_flag", {31'd0, tmo_flag_o}, 32'd0);
        chk("clr_keeps_cnt", {24'd0, tmo_cnt_o}, 32'd2);

        push_exp(32'hCAFE_F00D, 1'b0, 8'd2);
        do_txn("ack_on_expiry", 1'b0, 32'h3000_0010, 4'hF, 32'h0, TMO, 32'hCAFE_F00D, 1'b1, -1, TMO);

        push_exp(32'hDEAD_BEEF, 1'b1, 8'd3);
        do_txn("clr_vs_set", 1'b0, 32'h3000_0014, 4'hF, 32'h0, -1, 32'h0, 1'b1, TMO, TMO);

        // Abort: master drops cyc in REQ; no ack, no timeout may follow.
        @(negedge core_clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h3000_0018;
        stb_n = 0;
        for (int k = 0; k < 20 && stb_n < 4; k++) begin
            @(negedge core_clk);
            if (u_stb_o) stb_n++;
        end
        chk("abort_reached_req", stb_n, 32'd4);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge core_clk);
        chk("abort_ucyc", {31'd0, u_cyc_o}, 32'd0);
        chk("abort_ustb", {31'd0, u_stb_o}, 32'd0);
        repeat (TMO + 4) @(negedge core_clk);
        chk("abort_flag", {31'd0, tmo_flag_o}, 32'd1);
        chk("abort_cnt", {24'd0, tmo_cnt_o}, 32'd3);

        u_ack_i = 1'b1;
        repeat (5) @(negedge core_clk);
        u_ack_i = 1'b0;
        chk("idle_ack_ignored_ucyc", {31'd0, u_cyc_o}, 32'd0);

        // Reset during REQ.
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        stb_n = 0;
        for (int k = 0; k < 20 && stb_n < 3; k++) begin
            @(negedge core_clk);
            if (u_stb_o) stb_n++;
        end
        chk("rst_mid_reached_req", stb_n, 32'd3);
        core_rst = 1'b1;
        @(negedge core_clk);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        chk("rst_mid_ucyc", {31'd0, u_cyc_o}, 32'd0);
        chk("rst_mid_ustb", {31'd0, u_stb_o}, 32'd0);
        chk("rst_mid_ack", {31'd0, m_ack_o}, 32'd0);
        chk("rst_mid_flag", {31'd0, tmo_flag_o}, 32'd0);
        chk("rst_mid_cnt", {24'd0, tmo_cnt_o}, 32'd0);
        @(negedge core_clk);
        core_rst = 1'b0;
        repeat (3) @(negedge core_clk);

        for (int i = 0; i < 300; i++) begin
            push_exp(32'hDEAD_BEEF, 1'b1, (i + 1 > 255) ? 8'hFF : 8'(i + 1));
            do_txn("sat", 1'b0, 32'h3000_0100, 4'hF, 32'h0, -1, 32'h0, 1'b1, -1, TMO);
        end
        @(negedge core_clk);
        chk("sat_final_cnt", {24'd0, tmo_cnt_o}, 32'h0000_00FF);

        repeat (5) @(negedge core_clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
